// File: rtl/hash_batch_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// hash_batch_bus_arbiter_pkg
//
// Purpose:
//   Shared widths and types for the hash batch bus. This package holds the
//   field widths of one hash batch beat. HASH_BATCH_W is the packed width of
//   one whole beat. The package also gives the bit offset of each field
//   inside that packed vector.
//   The arbiter carries every source beat internally as one hash_batch_t.
//   It splits the fields apart again only at the registered bus output.
//
// Contents:
//   ADDR_WIDTH, HASH_ISSUE_WIDTH, META_MATCH_LEN_WIDTH  field widths
//   HASH_BATCH_W                                       packed beat width
//   *_LSB                                              field offsets in a beat
//   hash_batch_t                                       packed beat type
//   arb_state_e                                        arbiter FSM states
//   pack_beat()                                        field -> beat packing
// -----------------------------------------------------------------------------
package hash_batch_bus_arbiter_pkg;

    localparam int ADDR_WIDTH           = 16;
    localparam int HASH_ISSUE_WIDTH     = 4;
    localparam int META_MATCH_LEN_WIDTH = 3;

    // head + history_valid + history_addr + meta_match_len + can_ext + delim
    localparam int HASH_BATCH_W = ADDR_WIDTH
                                + HASH_ISSUE_WIDTH
                                + HASH_ISSUE_WIDTH * ADDR_WIDTH
                                + HASH_ISSUE_WIDTH * META_MATCH_LEN_WIDTH
                                + HASH_ISSUE_WIDTH
                                + 1;

    // Field placement inside a packed beat, delim in the LSB.
    localparam int DELIM_LSB      = 0;
    localparam int CAN_EXT_LSB    = DELIM_LSB + 1;
    localparam int META_LSB       = CAN_EXT_LSB + HASH_ISSUE_WIDTH;
    localparam int HIST_ADDR_LSB  = META_LSB + HASH_ISSUE_WIDTH * META_MATCH_LEN_WIDTH;
    localparam int HIST_VALID_LSB = HIST_ADDR_LSB + HASH_ISSUE_WIDTH * ADDR_WIDTH;
    localparam int HEAD_ADDR_LSB  = HIST_VALID_LSB + HASH_ISSUE_WIDTH;

    typedef logic [HASH_BATCH_W-1:0] hash_batch_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic hash_batch_t pack_beat(
        input logic [ADDR_WIDTH-1:0]                            head_addr,
        input logic [HASH_ISSUE_WIDTH-1:0]                      history_valid,
        input logic [HASH_ISSUE_WIDTH*ADDR_WIDTH-1:0]           history_addr,
        input logic [HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0] meta_match_len,
        input logic [HASH_ISSUE_WIDTH-1:0]                      meta_match_can_ext,
        input logic                                             delim
    );
        return {head_addr, history_valid, history_addr,
                meta_match_len, meta_match_can_ext, delim};
    endfunction

endpackage

// File: rtl/hash_batch_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// hash_batch_bus_arbiter_if
//
// Purpose:
//   Bundles the per-source hash batch inputs, the shared bus output and the
//   arbiter status signals into one interface.
//
// Modports:
//   slave  : arbiter side. It takes source beats and drives s_ready.
//            It also drives the bus payload, o_locked and o_owner, and it
//            takes o_ready from the first bus node.
//   master : environment side. This is the hash engines plus the bus sink.
//
// Signals (k = source index, slice k of each flattened vector):
//   s_valid / s_delim / s_ready      per-source handshake, NUM_SRC bits
//   s_head_addr                      NUM_SRC*ADDR_WIDTH
//   s_history_valid                  NUM_SRC*HASH_ISSUE_WIDTH
//   s_history_addr                   NUM_SRC*HASH_ISSUE_WIDTH*ADDR_WIDTH
//   s_meta_match_len                 NUM_SRC*HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH
//   s_meta_match_can_ext             NUM_SRC*HASH_ISSUE_WIDTH
//   o_valid / o_ready                bus handshake
//   o_*                              bus payload, one source slice wide
//   o_locked / o_owner               arbiter status
// -----------------------------------------------------------------------------
interface hash_batch_bus_arbiter_if
    import hash_batch_bus_arbiter_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int NUM_SRC_LOG2 = 2
) ();

    logic [NUM_SRC-1:0]                                         s_valid;
    logic [NUM_SRC*ADDR_WIDTH-1:0]                              s_head_addr;
    logic [NUM_SRC*HASH_ISSUE_WIDTH-1:0]                        s_history_valid;
    logic [NUM_SRC*HASH_ISSUE_WIDTH*ADDR_WIDTH-1:0]             s_history_addr;
    logic [NUM_SRC*HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0]   s_meta_match_len;
    logic [NUM_SRC*HASH_ISSUE_WIDTH-1:0]                        s_meta_match_can_ext;
    logic [NUM_SRC-1:0]                                         s_delim;
    logic [NUM_SRC-1:0]                                         s_ready;

    logic                                                       o_valid;
    logic [ADDR_WIDTH-1:0]                                      o_head_addr;
    logic [HASH_ISSUE_WIDTH-1:0]                                o_history_valid;
    logic [HASH_ISSUE_WIDTH*ADDR_WIDTH-1:0]                     o_history_addr;
    logic [HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0]           o_meta_match_len;
    logic [HASH_ISSUE_WIDTH-1:0]                                o_meta_match_can_ext;
    logic                                                       o_delim;
    logic                                                       o_ready;

    logic                                                       o_locked;
    logic [NUM_SRC_LOG2-1:0]                                    o_owner;

    modport slave (
        input  s_valid, s_head_addr, s_history_valid, s_history_addr,
               s_meta_match_len, s_meta_match_can_ext, s_delim,
        output s_ready,
        output o_valid, o_head_addr, o_history_valid, o_history_addr,
               o_meta_match_len, o_meta_match_can_ext, o_delim,
        input  o_ready,
        output o_locked, o_owner
    );

    modport master (
        output s_valid, s_head_addr, s_history_valid, s_history_addr,
               s_meta_match_len, s_meta_match_can_ext, s_delim,
        input  s_ready,
        input  o_valid, o_head_addr, o_history_valid, o_history_addr,
               o_meta_match_len, o_meta_match_can_ext, o_delim,
        output o_ready,
        input  o_locked, o_owner
    );

endinterface

// File: rtl/hash_batch_bus_arbiter_rr_pick_first.sv
// -----------------------------------------------------------------------------
// rr_pick_first
//
// Purpose:
//   Rotating-priority picker. It returns the first requester found when
//   searching upward from ptr, wrapping modulo NUM_SRC.
//   It is purely combinational and is reusable wherever a round-robin
//   winner is needed.
//
// Ports:
//   req    input   NUM_SRC       request vector
//   ptr    input   NUM_SRC_LOG2  highest-priority index (must be < NUM_SRC)
//   grant  output  NUM_SRC       one-hot winner, all zero when req == 0
//   idx    output  NUM_SRC_LOG2  winner index, 0 when req == 0
// -----------------------------------------------------------------------------
module rr_pick_first #(
    parameter int NUM_SRC      = 4,
    parameter int NUM_SRC_LOG2 = 2
) (
    input  logic [NUM_SRC-1:0]      req,
    input  logic [NUM_SRC_LOG2-1:0] ptr,
    output logic [NUM_SRC-1:0]      grant,
    output logic [NUM_SRC_LOG2-1:0] idx
);

    always_comb begin
        int                      cand;
        logic [NUM_SRC_LOG2-1:0] cand_idx;
        logic                    found;
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Explicit wrap keeps non-power-of-two NUM_SRC correct.
            cand = int'(ptr) + i;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            cand_idx = NUM_SRC_LOG2'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/hash_batch_bus_arbiter.sv
// -----------------------------------------------------------------------------
// hash_batch_bus_arbiter
//
// Purpose:
//   Merges the hash batch streams of NUM_SRC hash issue engines onto the
//   single hash batch bus. That bus feeds the first node of the job-PE chain.
//
//   Arbitration is round-robin at batch granularity. A batch ends with the
//   beat whose delim bit is 1. The winning source owns the bus until that
//   beat is accepted, so batches never interleave on the bus.
//   The bus output is one register stage deep. A new beat is loaded whenever
//   the register is empty or the bus node accepts the current beat.
//
// Ports:
//   clk    input  clock
//   rst_n  input  synchronous active-low reset. It drops any batch in
//                 flight and clears the output register, owner and rr_ptr.
//   bus    hash_batch_bus_arbiter_if.slave
//          s_*       per-source beats in, s_ready out
//          o_*       registered bus beat out, o_ready in
//          o_locked  high while a multi-beat batch is in progress
//          o_owner   source of the current or most recent grant
// -----------------------------------------------------------------------------
module hash_batch_bus_arbiter
    import hash_batch_bus_arbiter_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int NUM_SRC_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hash_batch_bus_arbiter_if.slave  bus
);

    localparam int AW = ADDR_WIDTH;
    localparam int IW = HASH_ISSUE_WIDTH;
    localparam int MW = META_MATCH_LEN_WIDTH;

    // Source beats packed to one vector each.
    hash_batch_t             src_beat [NUM_SRC];

    // Arbiter state.
    arb_state_e              state_q, state_d;
    logic [NUM_SRC_LOG2-1:0] owner_q, owner_d;
    logic [NUM_SRC_LOG2-1:0] rr_ptr_q, rr_ptr_d;

    // Grant path.
    logic [NUM_SRC-1:0]      pick_grant;
    logic [NUM_SRC_LOG2-1:0] pick_idx;
    logic [NUM_SRC-1:0]      owner_oh;
    logic [NUM_SRC_LOG2-1:0] win_idx;
    logic [NUM_SRC_LOG2-1:0] next_ptr;
    logic [NUM_SRC-1:0]      ready;
    logic                    load;
    logic                    accept;
    logic                    win_delim;

    // Output register.
    logic                    vld_p1;
    hash_batch_t             beat_p1;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_pack
        assign src_beat[k] = pack_beat(
            bus.s_head_addr[k*AW +: AW],
            bus.s_history_valid[k*IW +: IW],
            bus.s_history_addr[k*IW*AW +: IW*AW],
            bus.s_meta_match_len[k*IW*MW +: IW*MW],
            bus.s_meta_match_can_ext[k*IW +: IW],
            bus.s_delim[k]
        );
    end

    rr_pick_first #(
        .NUM_SRC      (NUM_SRC),
        .NUM_SRC_LOG2 (NUM_SRC_LOG2)
    ) u_pick (
        .req   (bus.s_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // ---- p0: grant and accept (combinational) ----
    assign load     = !vld_p1 || bus.o_ready;
    assign owner_oh = NUM_SRC'(1) << owner_q;
    assign win_idx  = (state_q == ARB_LOCKED) ? owner_q : pick_idx;

    // While locked, only the owner may be granted, even if its s_valid is
    // low. This keeps another source from slipping in mid-batch.
    always_comb begin
        ready = '0;
        if (rst_n && load) begin
            ready = (state_q == ARB_LOCKED) ? owner_oh : pick_grant;
        end
    end

    assign bus.s_ready = ready;
    assign accept      = |(ready & bus.s_valid);
    assign win_delim   = src_beat[win_idx][DELIM_LSB];
    assign next_ptr    = (win_idx == NUM_SRC_LOG2'(NUM_SRC - 1))
                       ? '0 : win_idx + NUM_SRC_LOG2'(1);

    // Next-state logic. rr_ptr only advances at a batch boundary. So the
    // next winner is chosen from the cycle after the delim beat is accepted.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    owner_d = win_idx;
                    if (win_delim) begin
                        rr_ptr_d = next_ptr;
                    end else begin
                        state_d = ARB_LOCKED;
                    end
                end
            end
            ARB_LOCKED: begin
                if (accept && win_delim) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // ---- p1: registered bus beat ----
    // The payload only changes on accept. This holds it stable under
    // back-pressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            beat_p1 <= '0;
        end else begin
            if (load) begin
                vld_p1 <= accept;
            end
            if (accept) begin
                beat_p1 <= src_beat[win_idx];
            end
        end
    end

    assign bus.o_valid              = vld_p1;
    assign bus.o_head_addr          = beat_p1[HEAD_ADDR_LSB  +: AW];
    assign bus.o_history_valid      = beat_p1[HIST_VALID_LSB +: IW];
    assign bus.o_history_addr       = beat_p1[HIST_ADDR_LSB  +: IW*AW];
    assign bus.o_meta_match_len     = beat_p1[META_LSB       +: IW*MW];
    assign bus.o_meta_match_can_ext = beat_p1[CAN_EXT_LSB    +: IW];
    assign bus.o_delim              = beat_p1[DELIM_LSB];
    assign bus.o_locked             = (state_q == ARB_LOCKED);
    assign bus.o_owner              = owner_q;

endmodule

// File: tb/tb_hash_batch_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hash_batch_bus_arbiter
//
// Purpose:
//   Self-checking bench for hash_batch_bus_arbiter with NUM_SRC = 4.
//   A vector table covers the steady-state cases: round-robin single beats,
//   a locked multi-beat batch and an owner stall. Hand-written sequences
//   cover reset, back-pressure hold, and reset in the middle of a batch.
//   Every source payload field is derived from (source, tag). Each bus
//   field can therefore be predicted independently of how the design
//   packs it internally.
// -----------------------------------------------------------------------------
module tb_hash_batch_bus_arbiter;
    import hash_batch_bus_arbiter_pkg::*;

    localparam int NS = 4;
    localparam int NL = 2;
    localparam int AW = ADDR_WIDTH;
    localparam int IW = HASH_ISSUE_WIDTH;
    localparam int MW = META_MATCH_LEN_WIDTH;
    localparam int NV = 18;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hash_batch_bus_arbiter_if #(.NUM_SRC(NS), .NUM_SRC_LOG2(NL)) bus ();

    hash_batch_bus_arbiter #(
        .NUM_SRC      (NS),
        .NUM_SRC_LOG2 (NL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] delim;
        logic       o_ready;
        logic [3:0] exp_ready;
        logic       exp_valid;
        logic [1:0] exp_owner;
        logic       exp_locked;
    } vec_t;

    vec_t vecs [NV];

    // Payload fields as a function of source index and tag.
    function automatic logic [AW-1:0] f_head(input int k, input logic [7:0] tag);
        return {4'hA, 4'(k), tag};
    endfunction

    function automatic logic [IW-1:0] f_hv(input int k, input logic [7:0] tag);
        return tag[3:0] ^ 4'(k);
    endfunction

    function automatic logic [IW*AW-1:0] f_ha(input int k, input logic [7:0] tag);
        logic [AW-1:0] h;
        h = f_head(k, tag);
        return {h ^ 16'h8001, h ^ 16'h4002, h ^ 16'h2004, h ^ 16'h1008};
    endfunction

    function automatic logic [IW*MW-1:0] f_ml(input int k, input logic [7:0] tag);
        return {tag[2:0], tag[5:3], 3'(k), ~tag[2:0]};
    endfunction

    function automatic logic [IW-1:0] f_ce(input int k, input logic [7:0] tag);
        return ~tag[7:4] ^ 4'(k);
    endfunction

    task automatic drive(input logic rst, input logic [NS-1:0] valid,
                         input logic [NS-1:0] delim, input logic ordy,
                         input logic [7:0] tag);
        rst_n       = rst;
        bus.s_valid = valid;
        bus.s_delim = delim;
        bus.o_ready = ordy;
        for (int k = 0; k < NS; k++) begin
            bus.s_head_addr[k*AW +: AW]             = f_head(k, tag);
            bus.s_history_valid[k*IW +: IW]         = f_hv(k, tag);
            bus.s_history_addr[k*IW*AW +: IW*AW]    = f_ha(k, tag);
            bus.s_meta_match_len[k*IW*MW +: IW*MW]  = f_ml(k, tag);
            bus.s_meta_match_can_ext[k*IW +: IW]    = f_ce(k, tag);
        end
    endtask

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string name, input logic exp_valid,
                                input logic [1:0] exp_owner, input logic exp_locked);
        check({name, " o_valid"},  128'(bus.o_valid),  128'(exp_valid));
        check({name, " o_owner"},  128'(bus.o_owner),  128'(exp_owner));
        check({name, " o_locked"}, 128'(bus.o_locked), 128'(exp_locked));
    endtask

    task automatic check_payload(input string name, input int k,
                                 input logic [7:0] tag, input logic delim);
        check({name, " head"},    128'(bus.o_head_addr),          128'(f_head(k, tag)));
        check({name, " hvalid"},  128'(bus.o_history_valid),      128'(f_hv(k, tag)));
        check({name, " haddr"},   128'(bus.o_history_addr),       128'(f_ha(k, tag)));
        check({name, " meta"},    128'(bus.o_meta_match_len),     128'(f_ml(k, tag)));
        check({name, " can_ext"}, 128'(bus.o_meta_match_can_ext), 128'(f_ce(k, tag)));
        check({name, " delim"},   128'(bus.o_delim),              128'(delim));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                valid    delim    rdy   s_ready  vld   own   lock
        // Single-beat batches from all sources: grants rotate 0,1,2,3,0.
        vecs[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0};
        // Source 1 sends a 3-beat batch while source 2 waits, then source 2.
        vecs[5]  = '{4'b0110, 4'b0100, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
        vecs[6]  = '{4'b0110, 4'b0100, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
        vecs[7]  = '{4'b0110, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[8]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
        // Only source 3 valid with rr_ptr=3, then source 0 beats source 3.
        vecs[9]  = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[10] = '{4'b1001, 4'b1000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
        // Locked owner 0 stalls for 4 cycles; source 3 must not be granted.
        for (int r = 11; r < 15; r++) begin
            vecs[r] = '{4'b1000, 4'b1000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1};
        end
        vecs[15] = '{4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[16] = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[17] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0};

        // Reset with every source requesting: no s_ready, all state cleared.
        drive(1'b0, 4'b1111, 4'b1111, 1'b1, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("reset s_ready", 128'(bus.s_ready), 128'(0));
        check_status("reset", 1'b0, 2'd0, 1'b0);
        check("reset head",  128'(bus.o_head_addr),    128'(0));
        check("reset haddr", 128'(bus.o_history_addr), 128'(0));

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].valid, vecs[i].delim, vecs[i].o_ready, 8'(8'h40 + i));
            #1;
            check($sformatf("row%0d s_ready", i), 128'(bus.s_ready), 128'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check_status($sformatf("row%0d", i), vecs[i].exp_valid,
                         vecs[i].exp_owner, vecs[i].exp_locked);
            if (vecs[i].exp_valid) begin
                check_payload($sformatf("row%0d", i), int'(vecs[i].exp_owner),
                              8'(8'h40 + i), vecs[i].delim[vecs[i].exp_owner]);
            end
        end

        // Back-pressure: source 1 starts a batch, then the bus stalls 5 cycles.
        @(negedge clk);
        drive(1'b1, 4'b0110, 4'b0000, 1'b1, 8'h80);
        #1;
        check("bp grant s_ready", 128'(bus.s_ready), 128'(4'b0010));
        @(posedge clk);
        #1;
        check_status("bp first", 1'b1, 2'd1, 1'b1);
        check_payload("bp first", 1, 8'h80, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(1'b1, 4'b0110, 4'b0010, 1'b0, 8'(8'h90 + c));
            #1;
            check($sformatf("bp%0d s_ready", c), 128'(bus.s_ready), 128'(0));
            @(posedge clk);
            #1;
            check_status($sformatf("bp%0d", c), 1'b1, 2'd1, 1'b1);
            check_payload($sformatf("bp%0d hold", c), 1, 8'h80, 1'b0);
        end
        // o_ready rises: the delim beat of source 1 is taken that same cycle.
        @(negedge clk);
        drive(1'b1, 4'b0110, 4'b0010, 1'b1, 8'hA0);
        #1;
        check("bp release s_ready", 128'(bus.s_ready), 128'(4'b0010));
        @(posedge clk);
        #1;
        check_status("bp release", 1'b1, 2'd1, 1'b0);
        check_payload("bp release", 1, 8'hA0, 1'b1);
        @(negedge clk);
        drive(1'b1, 4'b0100, 4'b0100, 1'b1, 8'hA1);
        #1;
        check("bp next s_ready", 128'(bus.s_ready), 128'(4'b0100));
        @(posedge clk);
        #1;
        check_status("bp next", 1'b1, 2'd2, 1'b0);
        check_payload("bp next", 2, 8'hA1, 1'b1);

        // Reset in the middle of a source 3 batch.
        @(negedge clk);
        drive(1'b1, 4'b1000, 4'b0000, 1'b1, 8'hB0);
        #1;
        check("mid grant s_ready", 128'(bus.s_ready), 128'(4'b1000));
        @(posedge clk);
        #1;
        check_status("mid locked", 1'b1, 2'd3, 1'b1);
        @(negedge clk);
        drive(1'b0, 4'b1000, 4'b0000, 1'b1, 8'hB1);
        #1;
        check("mid reset s_ready", 128'(bus.s_ready), 128'(0));
        @(posedge clk);
        #1;
        check_status("mid reset", 1'b0, 2'd0, 1'b0);
        check("mid reset head", 128'(bus.o_head_addr), 128'(0));
        @(negedge clk);
        drive(1'b1, 4'b1100, 4'b1100, 1'b1, 8'hB2);
        #1;
        check("post reset s_ready", 128'(bus.s_ready), 128'(4'b0100));
        @(posedge clk);
        #1;
        check_status("post reset", 1'b1, 2'd2, 1'b0);
        check_payload("post reset", 2, 8'hB2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
